// File: rtl/uop_sequencer_if.sv
// Bundle of the sequencer's control, microcode-ROM and datapath handshake signals.
// master = the sequencer itself, slave = the surrounding ROM/datapath/controller.
interface uop_sequencer_if #(
    parameter int ADDR_W = 6,
    parameter int PROG_W = 2,
    parameter int UOP_W  = 20
);
    logic                     ena;
    logic [PROG_W-1:0]        prog_sel;
    logic                     abort;
    logic                     rdy;
    logic                     err;
    logic [PROG_W+ADDR_W-1:0] rom_addr;
    logic [UOP_W-1:0]         rom_data;
    logic                     uop_valid;
    logic [UOP_W-1:0]         uop;
    logic                     uop_done;
    logic                     flag_in;
    logic [ADDR_W:0]          uop_count;

    modport master (
        input  ena, prog_sel, abort, rom_data, uop_done, flag_in,
        output rdy, err, rom_addr, uop_valid, uop, uop_count
    );

    modport slave (
        output ena, prog_sel, abort, rom_data, uop_done, flag_in,
        input  rdy, err, rom_addr, uop_valid, uop, uop_count
    );
endinterface

// File: rtl/uop_sequencer.sv
// Microprogram sequencer: walks a program in an external synchronous ROM and hands
// conditionally executed micro-ops to a datapath one at a time.
//
// state | meaning
// IDLE  | waiting for ena; rdy high
// FETCH | rom_addr = {prog, pc} presented to the ROM
// LATCH | ROM word captured, decoded: end, issue, or skip
// ISSUE | uop_valid high until uop_done
// WAIT  | one cycle after completion, then advance pc
module uop_sequencer #(
    parameter int ADDR_W     = 6,
    parameter int PROG_W     = 2,
    parameter int OPCODE_W   = 4,
    parameter int EXEC_W     = 2,
    parameter int UOP_W      = 20,
    parameter int OPCODE_RDY = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    uop_sequencer_if.master   bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_ISSUE = 3'd3,
        S_WAIT  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0]   PC_ONE  = 1;
    localparam logic [ADDR_W:0]     CNT_ONE = 1;
    localparam logic [OPCODE_W-1:0] OP_RDY  = OPCODE_W'(OPCODE_RDY);
    localparam logic [EXEC_W-1:0]   EX_IF_SET = EXEC_W'(1);
    localparam logic [EXEC_W-1:0]   EX_IF_CLR = EXEC_W'(2);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [PROG_W-1:0]   prog_q, prog_d;
    logic                flag_q, flag_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                err_q, err_d;
    logic                rdy_q, rdy_d;
    logic                valid_q, valid_d;
    logic [UOP_W-1:0]    uop_q, uop_d;

    logic [OPCODE_W-1:0] opcode;
    logic [EXEC_W-1:0]   exec;
    logic                exec_ok;
    logic                last_pc;

    assign opcode  = bus.rom_data[UOP_W-1 -: OPCODE_W];
    assign exec    = bus.rom_data[EXEC_W-1:0];
    assign last_pc = (pc_q == {ADDR_W{1'b1}});

    // exec code 3 is reserved and behaves like "always"
    always_comb begin
        exec_ok = 1'b1;
        if (exec == EX_IF_SET)
            exec_ok = flag_q;
        else if (exec == EX_IF_CLR)
            exec_ok = ~flag_q;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        prog_d  = prog_q;
        flag_d  = flag_q;
        count_d = count_q;
        err_d   = err_q;
        valid_d = valid_q;
        uop_d   = uop_q;

        if (state_q != S_IDLE && bus.abort) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.ena) begin
                        state_d = S_FETCH;
                        pc_d    = '0;
                        prog_d  = bus.prog_sel;
                        flag_d  = 1'b0;
                        count_d = '0;
                        err_d   = 1'b0;
                    end
                end
                S_FETCH: state_d = S_LATCH;
                S_LATCH: begin
                    uop_d = bus.rom_data;
                    if (opcode == OP_RDY) begin
                        state_d = S_IDLE;
                    end else if (exec_ok) begin
                        state_d = S_ISSUE;
                        valid_d = 1'b1;
                        count_d = count_q + CNT_ONE;
                    end else if (last_pc) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                        pc_d    = pc_q + PC_ONE;
                    end
                end
                S_ISSUE: begin
                    if (bus.uop_done) begin
                        state_d = S_WAIT;
                        valid_d = 1'b0;
                        flag_d  = bus.flag_in;
                    end
                end
                S_WAIT: begin
                    // the last word ran without an end marker: flag overrun rather than wrap
                    if (last_pc) begin
                        state_d = S_IDLE;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_FETCH;
                        pc_d    = pc_q + PC_ONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                end
            endcase
        end
        rdy_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            prog_q  <= '0;
            flag_q  <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b1;
            valid_q <= 1'b0;
            uop_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            prog_q  <= prog_d;
            flag_q  <= flag_d;
            count_q <= count_d;
            err_q   <= err_d;
            rdy_q   <= rdy_d;
            valid_q <= valid_d;
            uop_q   <= uop_d;
        end
    end

    assign bus.rdy       = rdy_q;
    assign bus.err       = err_q;
    assign bus.rom_addr  = {prog_q, pc_q};
    assign bus.uop_valid = valid_q;
    assign bus.uop       = uop_q;
    assign bus.uop_count = count_q;
endmodule

// File: tb/tb_uop_sequencer.sv
// Directed bench for uop_sequencer: synchronous ROM model, auto-responding datapath,
// and one task per scenario with hand-computed expectations.
module tb_uop_sequencer;
    logic clk;
    logic rst_n;

    uop_sequencer_if #(.ADDR_W(6), .PROG_W(2), .UOP_W(20)) bus ();

    uop_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [19:0] rom [256];
    logic [19:0] issued [$];
    int tests;
    int fails;

    logic auto_en;
    logic auto_d;
    logic resp_flag;
    logic man_d;
    logic man_f;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    // datapath model: answers every presented uop with a one-cycle done
    initial begin
        auto_d = 1'b0;
        forever begin
            @(negedge clk);
            auto_d = auto_en & bus.uop_valid;
            if (auto_en && bus.uop_valid)
                issued.push_back(bus.uop);
        end
    end

    assign bus.uop_done = auto_en ? auto_d : man_d;
    assign bus.flag_in  = auto_en ? resp_flag : man_f;

    task automatic start(input logic [1:0] p);
        @(negedge clk);
        bus.prog_sel = p;
        bus.ena = 1'b1;
        @(negedge clk);
        bus.ena = 1'b0;
    endtask

    task automatic wait_rdy(input int maxc);
        int n;
        n = 0;
        while (bus.rdy !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (bus.rdy !== 1'b1) begin
            tests++; fails++;
            $display("FAIL wait_rdy: rdy=%b after %0d cycles, required 1", bus.rdy, n);
        end
    endtask

    task automatic wait_valid(input int maxc);
        int n;
        n = 0;
        while (bus.uop_valid !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        if (bus.uop_valid !== 1'b1) begin
            tests++; fails++;
            $display("FAIL wait_valid: uop_valid=%b after %0d cycles, required 1", bus.uop_valid, n);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        tests++; if (bus.rdy !== 1'b1) begin fails++; $display("FAIL reset_rdy: got %b want 1", bus.rdy); end
        tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", bus.err); end
        tests++; if (bus.uop_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", bus.uop_valid); end
        tests++; if (bus.uop !== 20'h0) begin fails++; $display("FAIL reset_uop: got %h want 0", bus.uop); end
        tests++; if (bus.rom_addr !== 8'h0) begin fails++; $display("FAIL reset_rom_addr: got %h want 0", bus.rom_addr); end
        tests++; if (bus.uop_count !== 7'd0) begin fails++; $display("FAIL reset_count: got %0d want 0", bus.uop_count); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_program0();
        int base;
        int bad;
        base = issued.size();
        start(2'd0);
        tests++; if (bus.rdy !== 1'b0) begin fails++; $display("FAIL p0_rdy_low: got %b want 0", bus.rdy); end
        tests++; if (bus.rom_addr !== 8'd0) begin fails++; $display("FAIL p0_fetch_addr: got %0d want 0", bus.rom_addr); end
        @(negedge clk);
        tests++; if (bus.uop_valid !== 1'b0) begin fails++; $display("FAIL p0_latch_valid: got %b want 0", bus.uop_valid); end
        @(negedge clk);
        tests++; if (bus.uop_valid !== 1'b1) begin fails++; $display("FAIL p0_latency: uop_valid got %b want 1", bus.uop_valid); end
        tests++; if (bus.uop !== rom[0]) begin fails++; $display("FAIL p0_first_uop: got %h want %h", bus.uop, rom[0]); end
        wait_rdy(400);
        tests++; if (issued.size() - base != 27) begin fails++; $display("FAIL p0_issue_count: got %0d want 27", issued.size() - base); end
        bad = 0;
        for (int i = 0; i < 27 && base + i < issued.size(); i++)
            if (issued[base + i] !== rom[i]) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL p0_order: %0d words out of order, want 0", bad); end
        tests++; if (bus.uop_count !== 7'd27) begin fails++; $display("FAIL p0_uop_count: got %0d want 27", bus.uop_count); end
        tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL p0_err: got %b want 0", bus.err); end
    endtask

    task automatic test_exec(input logic f, input int e0, input int e1, input int e2, input int e3);
        int base;
        int bad;
        int exp_idx [4];
        exp_idx[0] = e0; exp_idx[1] = e1; exp_idx[2] = e2; exp_idx[3] = e3;
        resp_flag = f;
        base = issued.size();
        start(2'd1);
        tests++; if (bus.rom_addr !== 8'd64) begin fails++; $display("FAIL exec%0d_fetch_addr: got %0d want 64", f, bus.rom_addr); end
        wait_rdy(200);
        tests++; if (issued.size() - base != 4) begin fails++; $display("FAIL exec%0d_issues: got %0d want 4", f, issued.size() - base); end
        bad = 0;
        for (int k = 0; k < 4 && base + k < issued.size(); k++)
            if (issued[base + k] !== rom[64 + exp_idx[k]]) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL exec%0d_sequence: %0d wrong words, want 0", f, bad); end
        tests++; if (bus.uop_count !== 7'd4) begin fails++; $display("FAIL exec%0d_count: got %0d want 4", f, bus.uop_count); end
        resp_flag = 1'b0;
    endtask

    task automatic test_overrun();
        int base;
        base = issued.size();
        start(2'd2);
        wait_rdy(700);
        tests++; if (issued.size() - base != 64) begin fails++; $display("FAIL ovr_issues: got %0d want 64", issued.size() - base); end
        tests++; if (bus.uop_count !== 7'd64) begin fails++; $display("FAIL ovr_count: got %0d want 64", bus.uop_count); end
        tests++; if (bus.err !== 1'b1) begin fails++; $display("FAIL ovr_err: got %b want 1", bus.err); end
        tests++; if (bus.rdy !== 1'b1) begin fails++; $display("FAIL ovr_rdy: got %b want 1", bus.rdy); end
        start(2'd0);
        tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL ovr_err_clear: got %b want 0", bus.err); end
        wait_rdy(400);
        tests++; if (bus.uop_count !== 7'd27) begin fails++; $display("FAIL ovr_rerun_count: got %0d want 27", bus.uop_count); end
    endtask

    task automatic test_abort();
        int seen;
        auto_en = 1'b0;
        start(2'd0);
        wait_valid(10);
        bus.abort = 1'b1;
        man_d = 1'b1;
        man_f = 1'b1;
        @(negedge clk);
        tests++; if (bus.uop_valid !== 1'b0) begin fails++; $display("FAIL abort_valid: got %b want 0", bus.uop_valid); end
        tests++; if (bus.rdy !== 1'b1) begin fails++; $display("FAIL abort_rdy: got %b want 1", bus.rdy); end
        tests++; if (bus.uop_count !== 7'd1) begin fails++; $display("FAIL abort_count: got %0d want 1", bus.uop_count); end
        tests++; if (bus.err !== 1'b0) begin fails++; $display("FAIL abort_err: got %b want 0", bus.err); end
        bus.abort = 1'b0;
        man_d = 1'b0;
        man_f = 1'b0;
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.uop_valid !== 1'b0 || bus.rdy !== 1'b1) seen++;
        end
        tests++; if (seen != 0) begin fails++; $display("FAIL abort_stays_idle: %0d busy cycles, want 0", seen); end
        tests++; if (bus.rom_addr !== 8'd0) begin fails++; $display("FAIL abort_no_fetch: rom_addr got %0d want 0", bus.rom_addr); end
        auto_en = 1'b1;
    endtask

    task automatic test_reset_mid();
        int n;
        int sz;
        int base;
        start(2'd0);
        n = 0;
        while (!(bus.uop_valid === 1'b1 && bus.uop_count === 7'd3) && n < 40) begin
            @(negedge clk);
            n++;
        end
        tests++; if (bus.uop_count !== 7'd3) begin fails++; $display("FAIL rmid_reach: uop_count got %0d want 3", bus.uop_count); end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        tests++; if (bus.rdy !== 1'b1) begin fails++; $display("FAIL rmid_rdy: got %b want 1", bus.rdy); end
        tests++; if (bus.uop !== 20'h0) begin fails++; $display("FAIL rmid_uop: got %h want 0", bus.uop); end
        tests++; if (bus.rom_addr !== 8'd0) begin fails++; $display("FAIL rmid_rom_addr: got %0d want 0", bus.rom_addr); end
        tests++; if (bus.uop_count !== 7'd0) begin fails++; $display("FAIL rmid_count: got %0d want 0", bus.uop_count); end
        tests++; if (bus.uop_valid !== 1'b0) begin fails++; $display("FAIL rmid_valid: got %b want 0", bus.uop_valid); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        sz = issued.size();
        repeat (10) @(negedge clk);
        tests++; if (issued.size() != sz) begin fails++; $display("FAIL rmid_no_issue: %0d uops after reset, want 0", issued.size() - sz); end
        base = issued.size();
        start(2'd0);
        tests++; if (bus.rom_addr !== 8'd0) begin fails++; $display("FAIL rmid_restart_addr: got %0d want 0", bus.rom_addr); end
        wait_rdy(400);
        tests++; if (issued.size() <= base || issued[base] !== rom[0]) begin fails++; $display("FAIL rmid_restart_first: first uop wrong, want %h", rom[0]); end
        tests++; if (bus.uop_count !== 7'd27) begin fails++; $display("FAIL rmid_restart_count: got %0d want 27", bus.uop_count); end
    endtask

    task automatic test_ignored();
        int base;
        int bad;
        auto_en = 1'b0;
        man_d = 1'b1;
        man_f = 1'b1;
        repeat (2) @(negedge clk);
        man_d = 1'b0;
        man_f = 1'b0;
        @(negedge clk);
        tests++; if (bus.rdy !== 1'b1) begin fails++; $display("FAIL ign_done_rdy: got %b want 1", bus.rdy); end
        tests++; if (bus.uop_count !== 7'd27) begin fails++; $display("FAIL ign_done_count: got %0d want 27", bus.uop_count); end
        tests++; if (bus.rom_addr !== 8'd27) begin fails++; $display("FAIL ign_done_addr: got %0d want 27", bus.rom_addr); end
        auto_en = 1'b1;
        base = issued.size();
        start(2'd0);
        repeat (5) @(negedge clk);
        bus.prog_sel = 2'd2;
        bus.ena = 1'b1;
        @(negedge clk);
        bus.ena = 1'b0;
        wait_rdy(400);
        tests++; if (issued.size() - base != 27) begin fails++; $display("FAIL ign_ena_issues: got %0d want 27", issued.size() - base); end
        bad = 0;
        for (int i = 0; i < 27 && base + i < issued.size(); i++)
            if (issued[base + i] !== rom[i]) bad++;
        tests++; if (bad != 0) begin fails++; $display("FAIL ign_ena_order: %0d wrong words, want 0", bad); end
        tests++; if (bus.uop_count !== 7'd27) begin fails++; $display("FAIL ign_ena_count: got %0d want 27", bus.uop_count); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        auto_en = 1'b1;
        resp_flag = 1'b0;
        man_d = 1'b0;
        man_f = 1'b0;
        bus.ena = 1'b0;
        bus.prog_sel = 2'd0;
        bus.abort = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 20'h0;
        for (int i = 0; i < 27; i++) rom[i] = {4'h5, 14'(i), 2'd0};
        rom[64] = {4'h1, 14'h10, 2'd0};
        rom[65] = {4'h2, 14'h11, 2'd1};
        rom[66] = {4'h3, 14'h12, 2'd0};
        rom[67] = {4'h4, 14'h13, 2'd2};
        rom[68] = {4'h6, 14'h14, 2'd3};
        rom[69] = {4'h0, 14'h3fff, 2'd0};
        for (int i = 0; i < 64; i++) rom[128 + i] = {4'h7, 14'(i), 2'd0};
        rst_n = 1'b1;
        #3 rst_n = 1'b0;

        test_reset();
        test_program0();
        test_exec(1'b0, 0, 2, 3, 4);
        test_exec(1'b1, 0, 1, 2, 4);
        test_overrun();
        test_abort();
        test_reset_mid();
        test_ignored();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uop_sequencer.md
UOP_SEQUENCER -- requirements
Module: uop_sequencer

Interface
REQ-001 Parameter ADDR_W, default 6: microprogram counter width, giving 2^ADDR_W words per program.
REQ-002 Parameter PROG_W, default 2: program-select width, giving 2^PROG_W programs (double, add, ...).
REQ-003 Parameter OPCODE_W, default 4: opcode field width at uop[UOP_W-1 -: OPCODE_W].
REQ-004 Parameter EXEC_W, default 2: exec-condition field width at uop[EXEC_W-1:0].
REQ-005 Parameter UOP_W, default 20: total micro-instruction width.
REQ-006 Parameter OPCODE_RDY, default 0: opcode that terminates a microprogram.
REQ-007 clk  input  1  single clock; all state changes on rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 ena  input  1  start pulse; sampled only in IDLE.
REQ-010 prog_sel  input  PROG_W  program to run; latched with ena.
REQ-011 abort  input  1  synchronous abort of a running program.
REQ-012 rdy  output  1  high in IDLE; low while a program runs.
REQ-013 err  output  1  sticky overrun flag; cleared by the next accepted ena.
REQ-014 rom_addr  output  PROG_W+ADDR_W  {latched prog, pc} to the external synchronous microcode ROM.
REQ-015 rom_data  input  UOP_W  ROM word, valid one cycle after rom_addr.
REQ-016 uop_valid  output  1  micro-op presented to the datapath.
REQ-017 uop  output  UOP_W  micro-op word; held stable while uop_valid=1.
REQ-018 uop_done  input  1  datapath completion pulse for the presented micro-op.
REQ-019 flag_in  input  1  datapath compare result; valid with uop_done.
REQ-020 uop_count  output  ADDR_W+1  number of micro-ops issued in the current or last program.

Function
REQ-021 The block SHALL use states IDLE, FETCH, LATCH, ISSUE and WAIT.
- IDLE: ena=1 -> FETCH; pc=0; latch prog_sel; flag=0; uop_count=0; err=0.
- FETCH: rom_addr={prog,pc}; next state LATCH, one cycle.
- LATCH: capture rom_data into uop register; decode and branch per REQ-022..024.
- ISSUE: uop_valid=1; on uop_done -> WAIT.
- WAIT: one cycle; pc+1 -> FETCH.
REQ-022 In LATCH, an opcode equal to OPCODE_RDY SHALL return the block to IDLE without issuing, and uop_count SHALL be left unchanged.
REQ-023 In LATCH, the exec field SHALL gate issue: 0 = always; 1 = issue if flag=1; 2 = issue if flag=0; 3 = reserved, treated as always.
REQ-024 In LATCH, a suppressed uop SHALL skip directly to FETCH with pc+1, with no uop_valid pulse and no count increment.
REQ-025 The internal flag SHALL be updated from flag_in on every uop_done and SHALL hold otherwise.
REQ-026 uop_count SHALL increment by 1 on entry to ISSUE.
REQ-027 The latency from ena to the first uop_valid SHALL be 3 cycles (FETCH, LATCH, ISSUE asserted on the third edge).
REQ-028 A uop_done asserted outside ISSUE SHALL be ignored.
REQ-029 A uop_done asserted in the same cycle that uop_valid rises SHALL be accepted.
REQ-030 pc wrap: if pc = 2^ADDR_W-1 completes without an OPCODE_RDY word, the block SHALL set err=1 and return to IDLE; pc SHALL never wrap to 0 within a run.
REQ-031 abort=1 in any non-IDLE state SHALL drop uop_valid on the next edge and force IDLE; err SHALL be unchanged.
REQ-032 abort SHALL take priority over a simultaneous uop_done.
REQ-033 ena while not IDLE SHALL be ignored.
REQ-034 rdy SHALL be a registered output equal to (state==IDLE).

Reset
REQ-035 While rst_n=0, the block SHALL hold state=IDLE, rdy=1, err=0, uop_valid=0, uop=0, rom_addr=0, pc=0, flag=0 and uop_count=0, asynchronously.
REQ-036 A reset asserted mid-program SHALL abandon the program with no further uop_valid after rst_n rises.

Verification
REQ-037 Program 0 is 27 uops + RDY, exec always, with a 1-cycle uop_done -> exactly 27 uop_valid pulses in ROM order, uop_count=27, rdy returns high, err=0.
REQ-038 Uop with exec=1 and flag_in=0 at the preceding uop_done -> uop not issued, next ROM word issued, uop_count excludes it; repeat with flag_in=1 -> issued.
REQ-039 Program with no RDY word in all 64 words -> 64 issues, then err=1 and rdy=1; the next ena clears err.
REQ-040 abort asserted during ISSUE together with uop_done -> uop_valid=0 next cycle, IDLE, no further fetch.
REQ-041 rst_n pulsed low during WAIT -> all outputs at reset values immediately; ena afterwards restarts at pc=0.
REQ-042 ena pulsed while busy, plus uop_done while IDLE -> no effect on pc, uop_count or state.
